// File: rtl/serial_cmp_pkg.sv
// ============================================================================
// Module : serial_cmp_pkg
// Brief  : Shared state encoding and result-flag indices for the serial
//          magnitude comparator.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_cmp_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

    // Bit positions of the result flags inside the packed flag register.
    localparam int FLAG_LT = 0;
    localparam int FLAG_EQ = 1;
    localparam int FLAG_GT = 2;

endpackage

`default_nettype wire

// File: rtl/cmp2_slice.sv
// ============================================================================
// Module : cmp2_slice
// Brief  : Combinational 2-bit unsigned magnitude comparator slice.
//          y1 = A greater than B, y0 = A equal to B.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp2_slice (
    input  logic a1,
    input  logic a0,
    input  logic b1,
    input  logic b0,
    output logic y1,
    output logic y0
);

    logic w_hi_eq;

    assign w_hi_eq = a1 ~^ b1;
    assign y1      = (a1 & ~b1) | (w_hi_eq & a0 & ~b0);
    assign y0      = w_hi_eq & (a0 ~^ b0);

endmodule

`default_nettype wire

// File: rtl/serial_mag_compare_ctrl.sv
// ============================================================================
// Module : serial_mag_compare_ctrl
// Brief  : Sequencer comparing two WIDTH-bit unsigned operands MSB-first,
//          two bits per cycle, through one shared cmp2_slice.
//          Optional macro SERIAL_CMP_EARLY_EXIT_EN: finish on first
//          unequal slice instead of scanning all slices.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_mag_compare_ctrl
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int N    = WIDTH / 2;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("serial_mag_compare_ctrl: WIDTH must be even and >= 2");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [2:0]        flags_q, flags_d;
    // decided_q marks that an earlier slice already fixed the outcome.
    logic              decided_q, decided_d;
    logic              pend_gt_q, pend_gt_d;

    logic              slice_gt;
    logic              slice_eq;
    logic              last_slice;
    logic              run_exit;

    cmp2_slice u_slice (
        .a1 (a_q[{idx_q, 1'b1}]),
        .a0 (a_q[{idx_q, 1'b0}]),
        .b1 (b_q[{idx_q, 1'b1}]),
        .b0 (b_q[{idx_q, 1'b0}]),
        .y1 (slice_gt),
        .y0 (slice_eq)
    );

    assign last_slice = (idx_q == '0);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    assign run_exit = last_slice | ~slice_eq;
`else
    assign run_exit = last_slice;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        flags_d   = flags_q;
        decided_d = decided_q;
        pend_gt_d = pend_gt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    a_d       = a;
                    b_d       = b;
                    idx_d     = IDXW'(N - 1);
                    flags_d   = '0;
                    decided_d = 1'b0;
                    pend_gt_d = 1'b0;
                end
            end
            S_RUN: begin
                if (!last_slice) begin
                    idx_d = idx_q - IDXW'(1);
                end
                if (!decided_q && !slice_eq) begin
                    decided_d = 1'b1;
                    pend_gt_d = slice_gt;
                end
                // Flags are committed only on the edge that enters DONE.
                if (run_exit) begin
                    state_d = S_DONE;
                    if (decided_q) begin
                        flags_d[FLAG_GT] = pend_gt_q;
                        flags_d[FLAG_EQ] = 1'b0;
                        flags_d[FLAG_LT] = ~pend_gt_q;
                    end else begin
                        flags_d[FLAG_GT] = ~slice_eq & slice_gt;
                        flags_d[FLAG_EQ] = slice_eq;
                        flags_d[FLAG_LT] = ~slice_eq & ~slice_gt;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            flags_q   <= '0;
            decided_q <= 1'b0;
            pend_gt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            flags_q   <= flags_d;
            decided_q <= decided_d;
            pend_gt_q <= pend_gt_d;
        end
    end

    assign busy = (state_q == S_RUN) || (state_q == S_DONE);
    assign done = (state_q == S_DONE);
    assign gt   = flags_q[FLAG_GT];
    assign eq   = flags_q[FLAG_EQ];
    assign lt   = flags_q[FLAG_LT];

endmodule

`default_nettype wire
